programmable_sequence_detector: RTL and testbench

- Parametrised serial-bit pattern detector. Successor to the fixed overlapping sequence detector.
- Adds:
  - configurable pattern length;
  - a pattern register, reloadable at run time;
  - selectable overlapping or non-overlapping match mode;
  - an input-valid qualifier;
  - a saturating match counter.
- Sits on the serial input stream of the lab datapath and emits a one-cycle pulse per detected pattern.

---
 rtl/programmable_sequence_detector.sv | 87 ++++++++
 tb/tb_programmable_sequence_detector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/programmable_sequence_detector.sv
// Serial-bit pattern detector with a run-time reloadable pattern, selectable
// overlapping/non-overlapping matching, input-valid qualifier and saturating match counter.
module programmable_sequence_detector #(
  parameter int unsigned        SEQ_LEN         = 7,
  parameter int unsigned        CNT_WIDTH       = 8,
  parameter logic [SEQ_LEN-1:0] DEFAULT_PATTERN = 7'b0100110
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 x_in,
  input  logic                 x_valid,
  input  logic                 overlap_mode,
  input  logic                 load_pattern,
  input  logic [SEQ_LEN-1:0]   pattern_in,
  output logic                 y_out,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [SEQ_LEN-1:0]   pattern_out
);

  localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_ARMED = FILL_W'(SEQ_LEN - 1);

  if (SEQ_LEN < 2 || SEQ_LEN > 32) begin : g_bad_len
    $error("programmable_sequence_detector: SEQ_LEN must be in 2..32");
  end

  logic [SEQ_LEN-1:0]   pat;
  logic [SEQ_LEN-1:0]   hist;
  logic [FILL_W-1:0]    fill;

  logic [SEQ_LEN-1:0]   nxt_pat;
  logic [SEQ_LEN-1:0]   nxt_hist;
  logic [FILL_W-1:0]    nxt_fill;
  logic                 nxt_y;
  logic [CNT_WIDTH-1:0] nxt_count;
  logic [SEQ_LEN-1:0]   window;
  logic                 match;

  assign window = {hist[SEQ_LEN-2:0], x_in};
  // fill gating keeps stale zeros in hist from matching an all-zero pattern
  assign match  = (fill >= FILL_ARMED) && (window == pat);

  always_comb begin
    nxt_pat   = pat;
    nxt_hist  = hist;
    nxt_fill  = fill;
    nxt_y     = 1'b0;
    nxt_count = match_count;

    if (load_pattern) begin
      nxt_pat  = pattern_in;
      nxt_hist = '0;
      nxt_fill = '0;
    end else if (x_valid) begin
      nxt_hist = window;
      if (match) begin
        nxt_y    = 1'b1;
        nxt_fill = overlap_mode ? FILL_FULL : '0;
        if (match_count != '1) begin
          nxt_count = match_count + CNT_WIDTH'(1);
        end
      end else if (fill != FILL_FULL) begin
        nxt_fill = fill + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pat         <= DEFAULT_PATTERN;
      hist        <= '0;
      fill        <= '0;
      y_out       <= 1'b0;
      match_count <= '0;
    end else begin
      pat         <= nxt_pat;
      hist        <= nxt_hist;
      fill        <= nxt_fill;
      y_out       <= nxt_y;
      match_count <= nxt_count;
    end
  end

  assign pattern_out = pat;

endmodule

// File: tb/tb_programmable_sequence_detector.sv
// Directed self-checking bench for programmable_sequence_detector across three
// parameterisations (default 7-bit, 4-bit, 4-bit with 2-bit counter).
module tb_programmable_sequence_detector;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // instance a: defaults (SEQ_LEN=7, CNT_WIDTH=8, pattern 0100110)
  logic       rst_a, x_a, v_a, om_a, ld_a;
  logic [6:0] pi_a, pat_a;
  logic       y_a;
  logic [7:0] cnt_a;

  // instance b: SEQ_LEN=4
  logic       rst_b, x_b, v_b, om_b, ld_b;
  logic [3:0] pi_b, pat_b;
  logic       y_b;
  logic [7:0] cnt_b;

  // instance c: SEQ_LEN=4, CNT_WIDTH=2, pattern 1111
  logic       rst_c, x_c, v_c, om_c, ld_c;
  logic [3:0] pi_c, pat_c;
  logic       y_c;
  logic [1:0] cnt_c;

  programmable_sequence_detector u_a (
    .clock(clock), .reset(rst_a), .x_in(x_a), .x_valid(v_a), .overlap_mode(om_a),
    .load_pattern(ld_a), .pattern_in(pi_a), .y_out(y_a), .match_count(cnt_a),
    .pattern_out(pat_a)
  );

  programmable_sequence_detector #(
    .SEQ_LEN(4), .CNT_WIDTH(8), .DEFAULT_PATTERN(4'b1010)
  ) u_b (
    .clock(clock), .reset(rst_b), .x_in(x_b), .x_valid(v_b), .overlap_mode(om_b),
    .load_pattern(ld_b), .pattern_in(pi_b), .y_out(y_b), .match_count(cnt_b),
    .pattern_out(pat_b)
  );

  programmable_sequence_detector #(
    .SEQ_LEN(4), .CNT_WIDTH(2), .DEFAULT_PATTERN(4'b1111)
  ) u_c (
    .clock(clock), .reset(rst_c), .x_in(x_c), .x_valid(v_c), .overlap_mode(om_c),
    .load_pattern(ld_c), .pattern_in(pi_c), .y_out(y_c), .match_count(cnt_c),
    .pattern_out(pat_c)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [6:0]  pat7;
  logic [19:0] stream20;
  logic [7:0]  stream8;
  logic [7:0]  base_cnt;
  int          gaps [6];

  initial begin
    pat7     = 7'b0100110;
    stream20 = 20'b00011000100110100000;
    stream8  = 8'b10101010;
    gaps     = '{1, 2, 3, 1, 2, 3};

    {rst_a, x_a, v_a, om_a, ld_a} = 5'b00010; pi_a = '0;
    {rst_b, x_b, v_b, om_b, ld_b} = 5'b00010; pi_b = '0;
    {rst_c, x_c, v_c, om_c, ld_c} = 5'b00010; pi_c = '0;
    tick();
    chk("rst_a_y",   32'(y_a),   32'd0);
    chk("rst_a_cnt", 32'(cnt_a), 32'd0);
    chk("rst_a_pat", 32'(pat_a), 32'b0100110);
    chk("rst_b_pat", 32'(pat_b), 32'b1010);
    chk("rst_c_cnt", 32'(cnt_c), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Test 1: reset mid-stream
    v_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_a = pat7[6-i];
      tick();
    end
    rst_a = 1'b0; x_a = 1'b1;
    tick();
    chk("t1_rst_y",   32'(y_a),   32'd0);
    chk("t1_rst_cnt", 32'(cnt_a), 32'd0);
    chk("t1_rst_pat", 32'(pat_a), 32'b0100110);
    rst_a = 1'b1;
    for (int i = 4; i < 7; i++) begin
      x_a = pat7[6-i];
      tick();
      chk("t1_tail_y", 32'(y_a), 32'd0);
    end
    for (int i = 0; i < 7; i++) begin
      x_a = pat7[6-i];
      tick();
      chk("t1_full_y", 32'(y_a), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("t1_cnt", 32'(cnt_a), 32'd1);

    // Test 4: valid gaps with random x_in while invalid
    rst_a = 1'b0; v_a = 1'b0;
    tick();
    rst_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v_a = 1'b1; x_a = pat7[6-i];
      tick();
      chk("t4_bit_y", 32'(y_a), (i == 6) ? 32'd1 : 32'd0);
      if (i < 6) begin
        for (int g = 0; g < gaps[i]; g++) begin
          v_a = 1'b0; x_a = 1'($urandom_range(0, 1));
          tick();
          chk("t4_gap_y", 32'(y_a), 32'd0);
        end
      end
    end
    v_a = 1'b0;
    tick();
    chk("t4_after_y", 32'(y_a), 32'd0);
    chk("t4_cnt",     32'(cnt_a), 32'd1);

    // Test 2: continuous stream on defaults, overlap on
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1; v_a = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      x_a = stream20[20-i];
      tick();
      chk("t2_y", 32'(y_a), (i == 14) ? 32'd1 : 32'd0);
    end
    v_a = 1'b0;
    chk("t2_cnt", 32'(cnt_a), 32'd1);

    // Test 3: overlap vs non-overlap, 4-bit pattern 1010
    ld_b = 1'b1; pi_b = 4'b1010;
    tick();
    ld_b = 1'b0;
    chk("t3_pat", 32'(pat_b), 32'b1010);
    om_b = 1'b1; v_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      x_b = stream8[8-i];
      tick();
      chk("t3_ovl_y", 32'(y_b), (i == 4 || i == 6 || i == 8) ? 32'd1 : 32'd0);
    end
    chk("t3_ovl_cnt", 32'(cnt_b), 32'd3);
    v_b = 1'b0; ld_b = 1'b1; pi_b = 4'b1010;
    tick();
    chk("t3_load_clears_y", 32'(y_b), 32'd0);
    ld_b = 1'b0; om_b = 1'b0; v_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      x_b = stream8[8-i];
      tick();
      chk("t3_novl_y", 32'(y_b), (i == 4 || i == 8) ? 32'd1 : 32'd0);
    end
    chk("t3_novl_cnt", 32'(cnt_b), 32'd5);

    // Test 5: load collides with a valid bit; the bit is discarded
    om_b = 1'b1; base_cnt = cnt_b;
    ld_b = 1'b1; pi_b = 4'b1111; v_b = 1'b1; x_b = 1'b1;
    tick();
    ld_b = 1'b0;
    chk("t5_load_y",   32'(y_b),   32'd0);
    chk("t5_load_pat", 32'(pat_b), 32'b1111);
    chk("t5_load_cnt", 32'(cnt_b), 32'(base_cnt));
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t5_y", 32'(y_b), (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("t5_cnt", 32'(cnt_b), 32'(base_cnt) + 32'd2);

    // All-zero pattern: stale zeros in hist must not produce an early match
    v_b = 1'b0; ld_b = 1'b1; pi_b = 4'b0000;
    tick();
    ld_b = 1'b0; v_b = 1'b1; x_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t5_zero_y", 32'(y_b), (i >= 4) ? 32'd1 : 32'd0);
    end
    v_b = 1'b0;

    // Test 6: 2-bit counter saturates at 3 while pulses continue
    om_c = 1'b1; v_c = 1'b1; x_c = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t6_y", 32'(y_c), (i >= 4) ? 32'd1 : 32'd0);
      if (i >= 4) begin
        chk("t6_cnt", 32'(cnt_c), (i - 3 > 3) ? 32'd3 : 32'(i - 3));
      end
    end
    v_c = 1'b0;
    tick();
    chk("t6_idle_y",   32'(y_c),   32'd0);
    chk("t6_idle_cnt", 32'(cnt_c), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
